// File: rtl/div_16x8_seq.sv
// div_16x8_seq
//   Sequential restoring divider: 16-bit dividend by 8-bit divisor. It produces
//   a 16-bit quotient and an 8-bit remainder, one quotient bit per cycle.
//   It accepts one operation in IDLE. It computes for 16 cycles in CALC, then
//   holds the result in DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   dividend/divisor present (honoured only in IDLE)
//   in_ready   block can accept an operation (registered, high only in IDLE)
//   N, D       dividend / divisor, sampled on the accept edge
//   out_valid  Q/REM/DBZ hold a fresh result (registered, high only in DONE)
//   out_ready  consumer takes the result (honoured only in DONE)
//   Q, REM     quotient floor(N/D) and remainder N - Q*D
//   DBZ        divide-by-zero flag; when set, Q = 16'hFFFF and REM = N[7:0]

module div_16x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] N,
  input  logic [7:0]  D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  REM,
  output logic        DBZ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [8:0]  p_q,         p_d;      // partial remainder
  logic [15:0] sh_q,        sh_d;     // dividend shifts out, quotient shifts in
  logic [7:0]  d_q,         d_d;
  logic [7:0]  n_lo_q,      n_lo_d;   // dividend low byte, the REM value when D == 0
  logic [15:0] q_q,         q_d;
  logic [7:0]  rem_q,       rem_d;
  logic        dbz_q,       dbz_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;

  // One restoring step: bring in the next dividend bit, then subtract if it fits.
  logic [8:0]  t;
  logic        fits;
  logic [8:0]  p_step;
  logic [15:0] sh_step;

  always_comb begin
    t       = {p_q[7:0], sh_q[15]};
    fits    = (t >= {1'b0, d_q});
    // The partial remainder stays below D, so t < 2*D and t - D fits in 8 bits.
    p_step  = fits ? (t - {1'b0, d_q}) : t;
    sh_step = {sh_q[14:0], fits};

    // NOTE: every _d gets a hold default first, so no path through the case
    // leaves a signal unassigned and no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sh_d    = sh_q;
    d_d     = d_q;
    n_lo_d  = n_lo_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_d    = N;
          d_d     = D;
          n_lo_d  = N[7:0];
          p_d     = 9'd0;
          cnt_d   = 4'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        p_d   = p_step;
        sh_d  = sh_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          // D == 0 runs the same 16 steps so that latency is fixed.
          // The result is then forced to the defined divide-by-zero value.
          if (d_q == 8'd0) begin
            q_d   = 16'hFFFF;
            rem_d = n_lo_q;
            dbz_d = 1'b1;
          end else begin
            q_d   = sh_step;
            rem_d = p_step[7:0];
            dbz_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The handshake outputs are registered copies of the next-state decode.
    // No input reaches an output combinationally.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // All flops then update together on the edge, whatever order they are written in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      p_q         <= 9'd0;
      sh_q        <= 16'd0;
      d_q         <= 8'd0;
      n_lo_q      <= 8'd0;
      q_q         <= 16'd0;
      rem_q       <= 8'd0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      sh_q        <= sh_d;
      d_q         <= d_d;
      n_lo_q      <= n_lo_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign REM       = rem_q;
  assign DBZ       = dbz_q;

endmodule

// File: doc/div_16x8_seq.md
# div_16x8_seq

Sequential restoring divider, 16-bit dividend by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder. It is the inverse of the 8x8 multiplier family: it takes a 16-bit product and one 8-bit operand and recovers the other operand. The error-characterization flow uses it to quantify approximate-multiplier deviation. It also serves as a general divider wherever a multiplier result must be undone.

## Interface

Parameters: none. Widths are fixed at 16/8.

Ports:
- clk  input  1  — single clock; all state changes on rising edge.
- rst_n  input  1  — synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  — dividend/divisor present.
- in_ready  output  1  — block can accept an operation; high only in IDLE.
- N  input  16  — dividend; sampled on the accept edge (in_valid && in_ready).
- D  input  8  — divisor; sampled on the accept edge.
- out_valid  output  1  — Q/REM/DBZ hold a valid result; high only in DONE.
- out_ready  input  1  — consumer takes the result.
- Q  output  16  — quotient, floor(N/D).
- REM  output  8  — remainder, N − Q·D.
- DBZ  output  1  — divide-by-zero flag for the current result.

## Operation

- States:
  - IDLE: in_ready=1. On in_valid, latch N and D, clear the 9-bit partial remainder and the 4-bit step counter, and go to CALC.
  - CALC: one quotient bit per cycle, MSB first, 16 cycles. Counter 0→15; on count 15 go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE.
- Step arithmetic, in a 9-bit partial remainder P:
  - t = {P[7:0], N_shift[15]}.
  - If t ≥ {1'b0, D}: P ← t − D and the quotient bit is 1; otherwise P ← t and the quotient bit is 0.
  - The quotient shifts into the vacated dividend register (shared shift register).
  - P never exceeds 8 significant bits after subtraction. REM = P[7:0].
- Divide by zero (D==0):
  - Still spends the full 16 CALC cycles, so latency is fixed.
  - Result forced to Q=16'hFFFF, REM=N[7:0], DBZ=1.
  - DBZ=0 for every D≠0.
- Q, REM and DBZ are registered. They change only on the CALC→DONE edge and hold their value through DONE, IDLE and the next CALC, until the next result is written.
- in_valid is ignored outside IDLE, and N and D may change freely then.
- out_ready is ignored outside DONE.
- Reset, whenever asserted (including mid-CALC or in DONE):
  - Next state IDLE, counter 0, in-flight operation discarded.
  - Outputs after the reset edge: in_ready=1, out_valid=0, Q=0, REM=0, DBZ=0.
- Result is exact for all 2^24 input pairs with D≠0.

## Timing

- Accept edge E (in_valid && in_ready sampled high): state is CALC after E, and in_ready falls in the next cycle.
- CALC occupies edges E+1 … E+16. out_valid is high after edge E+16 with the final Q/REM/DBZ.
- Latency from accept edge to out_valid: 16 cycles.
- Output handshake at the first edge ≥ E+17 with out_ready=1. out_valid falls and in_ready rises after that edge.
- No same-cycle turnaround: with in_valid held high and out_ready held high, the next accept is at E+18. Minimum initiation interval is 18 cycles.
- Back-pressure: out_valid and the outputs remain stable for any number of cycles with out_ready=0.
- No combinational path from any input to any output. in_ready and out_valid decode state registers only.

## Test plan

- N=200, D=7 → after 16 cycles out_valid=1, Q=28, REM=4, DBZ=0. Handshake returns to IDLE; next accept is exactly 18 cycles after the first.
- N=65535, D=255 → Q=257, REM=0. N=5, D=9 → Q=0, REM=5. N=0, D=1 → Q=0, REM=0.
- N=1234, D=0 → after 16 cycles Q=16'hFFFF, REM=8'hD2, DBZ=1. A following N=1234, D=2 gives Q=617, REM=0, DBZ=0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, N and D. Check that Q/REM/DBZ are stable, in_ready=0, and no new accept occurs. Release → handshake, then IDLE.
- Reset mid-CALC: drive rst_n=0 at step 7 of N=40000, D=13. Next cycle: in_ready=1, out_valid=0, Q=REM=DBZ=0. A new N=40000, D=13 then completes with Q=3076, REM=12.
- Random and inverse check: 10^5 random (N, D≠0) pairs plus all products A·B of exact 8x8 multiplications with B≠0. Require Q==N/D and REM==N%D; for products require Q==A and REM==0. Latency must be exactly 16 cycles every time.
